// File: rtl/picture_target_bbox.sv
// -----------------------------------------------------------------------------
// picture_target_bbox
//
// Collects per-frame statistics from a binarized pixel stream. For each frame
// it tracks the bounding box of all foreground pixels (bit = 1) and how many
// foreground pixels there were. The result is published once per frame, on
// the rising edge of vsync. The input video timing and the pixel bit are also
// passed through with a 1-cycle delay, so a downstream overlay stage stays
// aligned with this block's latency.
//
// Handshake: there is no back-pressure. A pixel is valid when
// per_frame_clken & per_frame_href & ~per_frame_vsync on a rising clk edge.
// box_valid is a one-cycle pulse. It is not acknowledged, and the box_*
// outputs hold their values until the next publish.
//
// Ports
//   clk               pixel clock
//   rst               synchronous reset, active-high
//   per_frame_vsync   frame sync, high during vertical blanking
//   per_frame_href    line valid
//   per_frame_clken   pixel valid strobe
//   per_img_Bit       binary pixel, 1 = foreground
//   post_frame_*      per_frame_* delayed by 1 cycle
//   post_img_Bit      per_img_Bit delayed by 1 cycle
//   box_valid         one-cycle pulse when the box_* outputs are updated
//   box_found         last frame had >= MIN_PIXELS foreground pixels
//   box_x_min/x_max   horizontal extent of the last frame's box
//   box_y_min/y_max   vertical extent of the last frame's box
//   box_pix_cnt       foreground pixel count of the last frame (saturating)
//   dbg_state         current FSM state (0 = WAIT_SYNC, 1 = ACTIVE)
// -----------------------------------------------------------------------------
module picture_target_bbox #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int CNT_W      = 11,
  parameter int PIX_W      = 20,
  parameter int MIN_PIXELS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_Bit,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit,
  output logic             box_valid,
  output logic             box_found,
  output logic [CNT_W-1:0] box_x_min,
  output logic [CNT_W-1:0] box_x_max,
  output logic [CNT_W-1:0] box_y_min,
  output logic [CNT_W-1:0] box_y_max,
  output logic [PIX_W-1:0] box_pix_cnt,
  output logic             dbg_state
);

  typedef enum logic {
    ST_WAIT_SYNC = 1'b0,
    ST_ACTIVE    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [PIX_W-1:0] LP_PIX_MAX = {PIX_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_vsync_d;
  logic             r_href_d;
  logic             w_vs_rise;
  logic             w_hs_fall;
  logic             w_pix_strobe;
  logic             w_in_area;
  logic             w_fg_pix;

  logic             w_acc_en;
  logic             w_acc_clr;
  logic             w_publish;
  logic             w_found;

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;

  logic             r_seen;
  logic [CNT_W-1:0] r_x_min;
  logic [CNT_W-1:0] r_x_max;
  logic [CNT_W-1:0] r_y_min;
  logic [CNT_W-1:0] r_y_max;
  logic [PIX_W-1:0] r_cnt;

  // ---------------------------------------------------------------------------
  // Edge detection on the frame and line syncs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= per_frame_vsync;
      r_href_d  <= per_frame_href;
    end
  end

  assign w_vs_rise    = per_frame_vsync & ~r_vsync_d;
  assign w_hs_fall    = ~per_frame_href & r_href_d;
  // vsync masks the strobe, so a pixel on the vs_rise cycle is never counted.
  assign w_pix_strobe = per_frame_clken & per_frame_href & ~per_frame_vsync;

  // ---------------------------------------------------------------------------
  // 1-cycle pass-through of timing and pixel bit. It does not depend on the
  // FSM state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_Bit     <= per_img_Bit;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel coordinate counters. Both saturate and never wrap, so very long
  // lines or frames cannot alias back into the active area.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
    end else if (w_hs_fall) begin
      r_x <= '0;
    end else if (w_pix_strobe && (r_x != LP_CNT_MAX)) begin
      r_x <= r_x + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else if (w_vs_rise) begin
      r_y <= '0;
    end else if (w_hs_fall && (r_y != LP_CNT_MAX)) begin
      r_y <= r_y + CNT_W'(1);
    end
  end

  // The coordinate of the current pixel is the counter value before its
  // increment.
  assign w_in_area = (int'(r_x) < IMG_W) && (int'(r_y) < IMG_H);
  assign w_fg_pix  = w_acc_en & w_pix_strobe & per_img_Bit & w_in_area;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic. After reset the partial frame is meaningless, so
  // the FSM waits for a full frame boundary before it trusts the statistics.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_SYNC: if (w_vs_rise) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE:    w_state_nxt = ST_ACTIVE;
      default:      w_state_nxt = ST_WAIT_SYNC;
    endcase
  end

  // FSM: output logic
  always_comb begin
    w_acc_en  = 1'b0;
    w_publish = 1'b0;
    w_acc_clr = w_vs_rise;
    case (r_state)
      ST_WAIT_SYNC: begin
        w_acc_en  = 1'b0;
        w_publish = 1'b0;
      end
      ST_ACTIVE: begin
        w_acc_en  = 1'b1;
        w_publish = w_vs_rise;
      end
      default: begin
        w_acc_en  = 1'b0;
        w_publish = 1'b0;
      end
    endcase
  end

  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Bounding-box and count accumulators. The clear on vs_rise and the publish
  // happen on the same edge. The publish registers sample these values before
  // the clear takes effect. A pixel cannot coincide with the clear, because
  // vsync masks the strobe on that cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || w_acc_clr) begin
      r_seen  <= 1'b0;
      r_x_min <= '0;
      r_x_max <= '0;
      r_y_min <= '0;
      r_y_max <= '0;
      r_cnt   <= '0;
    end else if (w_fg_pix) begin
      if (!r_seen) begin
        // The first foreground pixel seeds both ends of the box.
        r_seen  <= 1'b1;
        r_x_min <= r_x;
        r_x_max <= r_x;
        r_y_min <= r_y;
        r_y_max <= r_y;
      end else begin
        if (r_x < r_x_min) r_x_min <= r_x;
        if (r_x > r_x_max) r_x_max <= r_x;
        if (r_y < r_y_min) r_y_min <= r_y;
        if (r_y > r_y_max) r_y_max <= r_y;
      end
      if (r_cnt != LP_PIX_MAX) begin
        r_cnt <= r_cnt + PIX_W'(1);
      end
    end
  end

  assign w_found = (int'(r_cnt) >= MIN_PIXELS);

  // ---------------------------------------------------------------------------
  // Publish registers. They hold until the next frame boundary. When the
  // target is too small, the coordinates are zeroed so stale boxes never
  // leak through.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      box_valid   <= 1'b0;
      box_found   <= 1'b0;
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      box_pix_cnt <= '0;
    end else begin
      box_valid <= w_publish;
      if (w_publish) begin
        box_pix_cnt <= r_cnt;
        if (w_found) begin
          box_found <= 1'b1;
          box_x_min <= r_x_min;
          box_x_max <= r_x_max;
          box_y_min <= r_y_min;
          box_y_max <= r_y_max;
        end else begin
          box_found <= 1'b0;
          box_x_min <= '0;
          box_x_max <= '0;
          box_y_min <= '0;
          box_y_max <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_picture_target_bbox.sv
module tb_picture_target_bbox;

  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int CNT_W = 11;
  localparam int PIX_W = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst, vsync, href, clken, bit_in;

  logic a_pvs, a_phs, a_pck, a_pbit, a_valid, a_found, a_dbg;
  logic [CNT_W-1:0] a_xmn, a_xmx, a_ymn, a_ymx;
  logic [PIX_W-1:0] a_cnt;
  logic b_pvs, b_phs, b_pck, b_pbit, b_valid, b_found, b_dbg;
  logic [CNT_W-1:0] b_xmn, b_xmx, b_ymn, b_ymx;
  logic [PIX_W-1:0] b_cnt;

  always #5 clk = ~clk;

  picture_target_bbox dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bit_in),
    .post_frame_vsync(a_pvs), .post_frame_href(a_phs),
    .post_frame_clken(a_pck), .post_img_Bit(a_pbit),
    .box_valid(a_valid), .box_found(a_found),
    .box_x_min(a_xmn), .box_x_max(a_xmx),
    .box_y_min(a_ymn), .box_y_max(a_ymx),
    .box_pix_cnt(a_cnt), .dbg_state(a_dbg)
  );

  // Second instance with a low threshold for the boundary-pixel scenario.
  picture_target_bbox #(.MIN_PIXELS(2)) dut2 (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bit_in),
    .post_frame_vsync(b_pvs), .post_frame_href(b_phs),
    .post_frame_clken(b_pck), .post_img_Bit(b_pbit),
    .box_valid(b_valid), .box_found(b_found),
    .box_x_min(b_xmn), .box_x_max(b_xmx),
    .box_y_min(b_ymn), .box_y_max(b_ymx),
    .box_pix_cnt(b_cnt), .dbg_state(b_dbg)
  );

  // {found, x_min, x_max, y_min, y_max, pix_cnt}
  logic [64:0] a_box, b_box;
  assign a_box = {a_found, a_xmn, a_xmx, a_ymn, a_ymx, a_cnt};
  assign b_box = {b_found, b_xmn, b_xmx, b_ymn, b_ymx, b_cnt};

  // ---------------------------------------------------------------------------
  // Picture description, reference model and scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_lines;
  int line_len [0:511];
  bit fg_map [int];          // foreground pixels keyed by y*4096+x

  logic [64:0] exp_q [$];    // expected publishes for dut: pushed by model, popped by tests
  logic [64:0] got_a, got_b, exp_a, exp_b;
  logic        got_valid, valid_after;
  int          extra_pulses;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int key(input int x, input int y);
    return y * 4096 + x;
  endfunction

  // Bounding box of every drawn foreground pixel that lies inside the image.
  function automatic logic [64:0] model_box(input int min_px);
    int cnt = 0;
    int xmn = 1 << 30, xmx = -1, ymn = 1 << 30, ymx = -1;
    int x, y;
    foreach (fg_map[k]) begin
      y = k / 4096;
      x = k % 4096;
      if (y < n_lines && y < IMG_H && x < line_len[y] && x < IMG_W) begin
        cnt++;
        xmn = (x < xmn) ? x : xmn;
        xmx = (x > xmx) ? x : xmx;
        ymn = (y < ymn) ? y : ymn;
        ymx = (y > ymx) ? y : ymx;
      end
    end
    if (cnt >= min_px)
      return {1'b1, CNT_W'(xmn), CNT_W'(xmx), CNT_W'(ymn), CNT_W'(ymx), PIX_W'(cnt)};
    return {1'b0, 44'd0, PIX_W'(cnt)};
  endfunction

  task automatic set_lines(input int nl, input int len);
    n_lines = nl;
    for (int y = 0; y < 512; y++) line_len[y] = len;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: plays the current picture as one frame and ends it with a vsync
  // rise, snapshotting the publish. When vs_pixel is set, a foreground strobe
  // rides on the vsync-rise cycle.
  // ---------------------------------------------------------------------------
  task automatic drive_frame(input int gap_pct, input bit vs_pixel);
    exp_q.push_back(model_box(16));
    vsync = 1'b0; href = 1'b0; clken = 1'b0; bit_in = 1'b0;
    repeat (3) tick;
    for (int y = 0; y < n_lines; y++) begin
      for (int x = 0; x < line_len[y]; x++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          href = 1'b1; clken = 1'b0; bit_in = 1'($urandom_range(1));
          tick;
        end
        href = 1'b1; clken = 1'b1; bit_in = fg_map.exists(key(x, y));
        tick;
      end
      href = 1'b0; clken = 1'b0; bit_in = 1'b0;
      repeat (2) tick;
    end
    repeat (2) tick;
    vsync = 1'b1;
    if (vs_pixel) begin
      href = 1'b1; clken = 1'b1; bit_in = 1'b1;
    end
    tick;
    got_valid = a_valid;
    got_a     = a_box;
    got_b     = b_box;
    href = 1'b0; clken = 1'b0; bit_in = 1'b0;
    tick;
    valid_after  = a_valid;
    extra_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (a_valid) extra_pulses++;
    end
    exp_a = exp_q.pop_front();
    exp_b = model_box(2);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    logic [70:0] all_a, all_b;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; bit_in = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vsync = 1'($urandom_range(1)); href = 1'($urandom_range(1));
      clken = 1'($urandom_range(1)); bit_in = 1'($urandom_range(1));
      tick;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      href = 1'b1; clken = 1'($urandom_range(1)); bit_in = 1'($urandom_range(1));
      tick;
      all_a = {a_pvs, a_phs, a_pck, a_pbit, a_valid, a_box, a_dbg};
      all_b = {b_pvs, b_phs, b_pck, b_pbit, b_valid, b_box, b_dbg};
      n_checks++;
      if (all_a !== 71'd0 || all_b !== 71'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h / %h expected 0", all_a, all_b);
      end
    end
    rst = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; bit_in = 1'b0;
    tick;
    // First frame after reset: its closing vsync only arms the block.
    fg_map.delete();
    set_lines(5, 8);
    for (int i = 0; i < 6; i++) fg_map[key(i, 2)] = 1'b1;
    drive_frame(0, 1'b0);
    void'(exp_q.pop_back());
    n_checks++;
    if (got_valid !== 1'b0 || extra_pulses != 0) begin
      n_fail++;
      $display("FAIL reset_first_vs: valid %b pulses %0d expected 0 0", got_valid, extra_pulses);
    end
    n_checks++;
    if (a_dbg !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state_active: got %b expected 1", a_dbg);
    end
    // Second frame produces the first publish.
    fg_map.delete();
    set_lines(6, 8);
    for (int y = 1; y <= 4; y++) for (int x = 2; x <= 5; x++) fg_map[key(x, y)] = 1'b1;
    exp_q.push_back(65'd0);
    void'(exp_q.pop_back());
    drive_frame(10, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_a !== exp_a ||
        got_a !== {1'b1, 11'd2, 11'd5, 11'd1, 11'd4, 20'd16}) begin
      n_fail++;
      $display("FAIL reset_second_vs: valid %b box %h expected 1 %h", got_valid, got_a, exp_a);
    end
  endtask

  task automatic test_block;
    fg_map.delete();
    set_lines(60, 110);
    for (int y = 50; y <= 59; y++) for (int x = 100; x <= 109; x++) fg_map[key(x, y)] = 1'b1;
    drive_frame(0, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || valid_after !== 1'b0 || extra_pulses != 0) begin
      n_fail++;
      $display("FAIL block_pulse: valid %b after %b pulses %0d expected 1 0 0",
               got_valid, valid_after, extra_pulses);
    end
    n_checks++;
    if (got_a !== {1'b1, 11'd100, 11'd109, 11'd50, 11'd59, 20'd100} || got_a !== exp_a) begin
      n_fail++;
      $display("FAIL block_box: got %h expected %h", got_a, exp_a);
    end
  endtask

  task automatic test_threshold;
    fg_map.delete();
    set_lines(20, 30);
    while (fg_map.size() < 15) fg_map[key($urandom_range(29), $urandom_range(19))] = 1'b1;
    drive_frame(20, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_a !== exp_a || got_a !== {1'b0, 44'd0, 20'd15}) begin
      n_fail++;
      $display("FAIL thresh_15: valid %b box %h expected 1 %h", got_valid, got_a, exp_a);
    end
    while (fg_map.size() < 16) fg_map[key($urandom_range(29), $urandom_range(19))] = 1'b1;
    drive_frame(20, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_a !== exp_a || got_a[64] !== 1'b1 || got_a[19:0] !== 20'd16) begin
      n_fail++;
      $display("FAIL thresh_16: valid %b box %h expected 1 %h", got_valid, got_a, exp_a);
    end
  endtask

  task automatic test_boundary;
    fg_map.delete();
    set_lines(480, 1);
    line_len[479] = 641;
    fg_map[key(0, 0)]     = 1'b1;
    fg_map[key(639, 479)] = 1'b1;
    fg_map[key(640, 479)] = 1'b1;
    drive_frame(0, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_b !== exp_b ||
        got_b !== {1'b1, 11'd0, 11'd639, 11'd0, 11'd479, 20'd2}) begin
      n_fail++;
      $display("FAIL boundary_box: valid %b box %h expected 1 %h", got_valid, got_b, exp_b);
    end
    n_checks++;
    if (got_a !== {1'b0, 44'd0, 20'd2}) begin
      n_fail++;
      $display("FAIL boundary_default_thresh: got %h expected %h", got_a, {1'b0, 44'd0, 20'd2});
    end
  endtask

  task automatic test_passthrough;
    logic [3:0] sent;
    for (int i = 0; i < 200; i++) begin
      vsync = 1'($urandom_range(1)); href = 1'($urandom_range(1));
      clken = 1'($urandom_range(1)); bit_in = 1'($urandom_range(1));
      sent = {vsync, href, clken, bit_in};
      tick;
      n_checks++;
      if ({a_pvs, a_phs, a_pck, a_pbit} !== sent) begin
        n_fail++;
        $display("FAIL passthrough_cycle%0d: got %b expected %b", i, {a_pvs, a_phs, a_pck, a_pbit}, sent);
      end
    end
    vsync = 1'b0; href = 1'b0; clken = 1'b0; bit_in = 1'b0;
    repeat (2) tick;
    vsync = 1'b1;
    repeat (3) tick;
    // Gapped frame whose closing vsync carries a foreground strobe.
    fg_map.delete();
    set_lines(12, 24);
    while (fg_map.size() < 20) fg_map[key($urandom_range(23), $urandom_range(11))] = 1'b1;
    drive_frame(30, 1'b1);
    n_checks++;
    if (got_valid !== 1'b1 || got_a !== exp_a || got_a[19:0] !== 20'd20) begin
      n_fail++;
      $display("FAIL vs_rise_pixel: valid %b box %h expected 1 %h", got_valid, got_a, exp_a);
    end
    // Empty frame: also realigns the line counter after the strobe above.
    fg_map.delete();
    set_lines(3, 4);
    drive_frame(0, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_a !== 65'd0) begin
      n_fail++;
      $display("FAIL empty_frame: valid %b box %h expected 1 0", got_valid, got_a);
    end
  endtask

  task automatic test_back_to_back;
    fg_map.delete();
    set_lines(21, 21);
    for (int y = 10; y <= 20; y++) for (int x = 10; x <= 20; x++) fg_map[key(x, y)] = 1'b1;
    drive_frame(5, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_a !== {1'b1, 11'd10, 11'd20, 11'd10, 11'd20, 20'd121}) begin
      n_fail++;
      $display("FAIL b2b_frame1: valid %b box %h expected 1 %h", got_valid, got_a, exp_a);
    end
    fg_map.delete();
    drive_frame(5, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_a !== 65'd0 || got_b !== 65'd0) begin
      n_fail++;
      $display("FAIL b2b_frame2: valid %b box %h / %h expected 1 0", got_valid, got_a, got_b);
    end
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 6; f++) begin
      fg_map.delete();
      n_lines = $urandom_range(30, 4);
      for (int y = 0; y < 512; y++) line_len[y] = $urandom_range(40, 1);
      for (int i = 0; i < int'($urandom_range(40)); i++)
        fg_map[key($urandom_range(45), $urandom_range(n_lines + 2))] = 1'b1;
      drive_frame($urandom_range(40), 1'($urandom_range(1)));
      // The vsync-rise strobe leaves y offset; an empty frame resets it.
      n_checks++;
      if (got_valid !== 1'b1 || got_a !== exp_a || got_b !== exp_b) begin
        n_fail++;
        $display("FAIL random_frame%0d: box %h / %h expected %h / %h", f, got_a, got_b, exp_a, exp_b);
      end
      fg_map.delete();
      set_lines(2, 3);
      drive_frame(0, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_block;
    test_threshold;
    test_boundary;
    test_passthrough;
    test_back_to_back;
    test_random_frames;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
